// File: rtl/probe_source.sv
// probe_source
//   Leaf stage of the probe uplink tree. A wide probe sample is captured on
//   PROBE_EN (gated by ENABLE) into a small FIFO, then sent upstream as one
//   header word followed by DWIDTH/32 data words, least-significant first.
//
// Ports
//   UCLK        clock, rising edge
//   URST        synchronous active-high reset
//   PROBE_DATA  sample value (DWIDTH bits)
//   PROBE_EN    capture strobe
//   ENABLE      capture enable (gates PROBE_EN only; draining continues)
//   DATAUP      uplink word (registered)
//   DATAVALID   DATAUP holds a valid word
//   DELAY       pending or in-flight data, holds off the upstream mux
//   ACK         word transfers when DATAVALID && ACK
//   DROPS       saturating count of samples dropped on a full FIFO
//
// Header word: {PROBE_ID, NW[7:0], 7'b0, LOST}
module probe_source #(
  parameter logic [15:0] PROBE_ID = 16'h0001,
  parameter int          DWIDTH   = 64,
  parameter int          DEPTH    = 4
) (
  input  logic              UCLK,
  input  logic              URST,
  input  logic [DWIDTH-1:0] PROBE_DATA,
  input  logic              PROBE_EN,
  input  logic              ENABLE,
  output logic [31:0]       DATAUP,
  output logic              DATAVALID,
  output logic              DELAY,
  input  logic              ACK,
  output logic [15:0]       DROPS
);

  localparam int NW = DWIDTH / 32;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [7:0]    NW8  = 8'(NW);
  localparam logic [IW-1:0] LAST = IW'(NW - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t            state;
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [IW-1:0]     idx;
  logic              lost;
  logic [DWIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]     occ;
  logic [PW-1:0]     occ_nx;
  logic              full;
  logic              push;
  logic              drop;
  logic              hdr_acc;
  logic              pop;
  logic              lost_nx;
  logic              vld_nx;
  logic [DWIDTH-1:0] head;

  function automatic logic [31:0] hdr_word(input logic lost_bit);
    return {PROBE_ID, NW8, 7'b0, lost_bit};
  endfunction

  function automatic logic [31:0] word_of(input logic [DWIDTH-1:0] d,
                                          input logic [IW-1:0] i);
    return d[32*int'(i) +: 32];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    occ     = wptr - rptr;
    full    = (occ == PW'(DEPTH));
    // Full is judged on the pre-pop occupancy: a pop in the same cycle
    // does not make room for the incoming sample.
    push    = PROBE_EN && ENABLE && !full;
    drop    = PROBE_EN && ENABLE && full;
    hdr_acc = (state == HDR) && ACK;
    pop     = (state == DATA) && ACK && (idx == LAST);
    occ_nx  = occ + PW'(push) - PW'(pop);
    // A drop in the same cycle as header acceptance wins, so the loss is
    // reported in the following header instead of being silently cleared.
    lost_nx = drop || (lost && !hdr_acc);
    head    = mem[rptr[AW-1:0]];
    if (state == IDLE) vld_nx = (occ_nx != '0);
    else               vld_nx = !(pop && (occ_nx == '0));
  end

  // Sample storage; emptiness is tracked by the pointers, so no reset here.
  always_ff @(posedge UCLK) begin
    if (push) mem[wptr[AW-1:0]] <= PROBE_DATA;
  end

  always_ff @(posedge UCLK) begin
    if (URST) begin
      state     <= IDLE;
      wptr      <= '0;
      rptr      <= '0;
      idx       <= '0;
      lost      <= 1'b0;
      DROPS     <= '0;
      DATAUP    <= '0;
      DATAVALID <= 1'b0;
      DELAY     <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      if (drop) DROPS <= sat_inc(DROPS);
      lost  <= lost_nx;
      DELAY <= vld_nx || (occ_nx != '0);

      case (state)
        IDLE: begin
          // Looking at the post-push occupancy gives one-cycle push-to-valid.
          if (occ_nx != '0) begin
            state     <= HDR;
            DATAVALID <= 1'b1;
            DATAUP    <= hdr_word(lost_nx);
          end
        end
        HDR: begin
          if (ACK) begin
            state  <= DATA;
            idx    <= '0;
            DATAUP <= word_of(head, '0);
          end else begin
            // The LOST bit follows the live flag while waiting, so the
            // header that gets accepted carries the flag it clears.
            DATAUP <= hdr_word(lost_nx);
          end
        end
        DATA: begin
          if (ACK) begin
            if (idx != LAST) begin
              idx    <= idx + IW'(1);
              DATAUP <= word_of(head, idx + IW'(1));
            end else begin
              idx <= '0;
              if (occ_nx != '0) begin
                state  <= HDR;
                DATAUP <= hdr_word(lost_nx);
              end else begin
                state     <= IDLE;
                DATAVALID <= 1'b0;
                DATAUP    <= '0;
              end
            end
          end
        end
        default: begin
          state     <= IDLE;
          DATAVALID <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_probe_source.sv
// Directed bench for probe_source with DWIDTH=64, DEPTH=4, PROBE_ID=1.
module tb_probe_source;

  logic        UCLK;
  logic        URST;
  logic [63:0] PROBE_DATA;
  logic        PROBE_EN;
  logic        ENABLE;
  logic [31:0] DATAUP;
  logic        DATAVALID;
  logic        DELAY;
  logic        ACK;
  logic [15:0] DROPS;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] H0 = 32'h0001_0200;
  localparam logic [31:0] H1 = 32'h0001_0201;

  probe_source #(.PROBE_ID(16'h0001), .DWIDTH(64), .DEPTH(4)) dut (
    .UCLK(UCLK), .URST(URST), .PROBE_DATA(PROBE_DATA), .PROBE_EN(PROBE_EN),
    .ENABLE(ENABLE), .DATAUP(DATAUP), .DATAVALID(DATAVALID), .DELAY(DELAY),
    .ACK(ACK), .DROPS(DROPS)
  );

  initial UCLK = 1'b0;
  always #5 UCLK = ~UCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] smp(input int k);
    return {32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k)};
  endfunction

  task automatic tick();
    @(posedge UCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expects the header of sample k to be showing with ACK=1; checks the two
  // data words, then either the next header or a return to idle.
  task automatic pkt(input string tag, input int k, input bit more, input logic [31:0] nxt);
    logic [63:0] s;
    s = smp(k);
    tick(); chk({tag, "_w0"}, DATAUP, s[31:0]);
    tick(); chk({tag, "_w1"}, DATAUP, s[63:32]);
    tick();
    if (more) chk({tag, "_nexthdr"}, DATAUP, nxt);
    else      chk({tag, "_idle"}, {31'b0, DATAVALID}, 32'd0);
  endtask

  initial begin
    URST = 1'b1; PROBE_DATA = '0; PROBE_EN = 1'b0; ENABLE = 1'b1; ACK = 1'b0;
    tick(); tick();
    chk("rst_valid", {31'b0, DATAVALID}, 32'd0);
    chk("rst_delay", {31'b0, DELAY}, 32'd0);
    chk("rst_drops", {16'b0, DROPS}, 32'd0);
    chk("rst_dataup", DATAUP, 32'd0);
    URST = 1'b0;
    tick();

    // Single packet with ACK held high.
    ACK = 1'b1; PROBE_DATA = 64'h1111_2222_3333_4444; PROBE_EN = 1'b1;
    tick(); PROBE_EN = 1'b0;
    chk("t1_hdr", DATAUP, H0);
    chk("t1_vld0", {31'b0, DATAVALID}, 32'd1);
    chk("t1_delay", {31'b0, DELAY}, 32'd1);
    tick(); chk("t1_w0", DATAUP, 32'h3333_4444);
    chk("t1_vld1", {31'b0, DATAVALID}, 32'd1);
    tick(); chk("t1_w1", DATAUP, 32'h1111_2222);
    chk("t1_vld2", {31'b0, DATAVALID}, 32'd1);
    tick(); chk("t1_vld_end", {31'b0, DATAVALID}, 32'd0);
    chk("t1_delay_end", {31'b0, DELAY}, 32'd0);

    // Header stall for 5 cycles.
    ACK = 1'b0; PROBE_DATA = 64'hAAAA_BBBB_CCCC_DDDD; PROBE_EN = 1'b1;
    tick(); PROBE_EN = 1'b0;
    chk("t2_hdr", DATAUP, H0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_stall_hdr", DATAUP, H0);
      chk("t2_stall_vld", {31'b0, DATAVALID}, 32'd1);
    end
    ACK = 1'b1;
    tick(); chk("t2_w0", DATAUP, 32'hCCCC_DDDD);
    tick(); chk("t2_w1", DATAUP, 32'hAAAA_BBBB);
    tick(); chk("t2_idle", {31'b0, DATAVALID}, 32'd0);

    // Six strobes into a depth-4 FIFO with the uplink stalled.
    ACK = 1'b0;
    for (int k = 0; k < 6; k++) begin
      PROBE_DATA = smp(k); PROBE_EN = 1'b1;
      tick();
    end
    PROBE_EN = 1'b0;
    chk("t3_drops", {16'b0, DROPS}, 32'd2);
    chk("t3_delay", {31'b0, DELAY}, 32'd1);
    chk("t3_hdr_lost", DATAUP, H1);
    ACK = 1'b1;
    pkt("t3_p0", 0, 1'b1, H0);
    pkt("t3_p1", 1, 1'b1, H0);
    pkt("t3_p2", 2, 1'b1, H0);
    pkt("t3_p3", 3, 1'b0, 32'd0);
    chk("t3_drops_kept", {16'b0, DROPS}, 32'd2);

    // Drop coinciding with header acceptance keeps LOST set.
    ACK = 1'b0;
    for (int k = 10; k < 14; k++) begin
      PROBE_DATA = smp(k); PROBE_EN = 1'b1;
      tick();
    end
    chk("t4_hdr_clean", DATAUP, H0);
    PROBE_DATA = smp(99); ACK = 1'b1;
    tick(); PROBE_EN = 1'b0;
    chk("t4_w0", DATAUP, 32'h2000_000A);
    chk("t4_drops", {16'b0, DROPS}, 32'd3);
    tick(); chk("t4_w1", DATAUP, 32'h1000_000A);
    tick(); chk("t4_hdr_lost", DATAUP, H1);
    pkt("t4_p11", 11, 1'b1, H0);
    pkt("t4_p12", 12, 1'b1, H0);
    pkt("t4_p13", 13, 1'b0, 32'd0);

    // Saturation of DROPS.
    ACK = 1'b0;
    for (int k = 20; k < 24; k++) begin
      PROBE_DATA = smp(k); PROBE_EN = 1'b1;
      tick();
    end
    PROBE_DATA = smp(77);
    for (int i = 0; i < 65531; i++) tick();
    chk("t4_drops_fffe", {16'b0, DROPS}, 32'h0000_FFFE);
    for (int i = 0; i < 9; i++) tick();
    PROBE_EN = 1'b0;
    chk("t4_drops_sat", {16'b0, DROPS}, 32'h0000_FFFF);
    chk("t4_sat_hdr", DATAUP, H1);

    // Reset during data word 1.
    ACK = 1'b1;
    tick(); chk("t5_w0", DATAUP, 32'h2000_0014);
    tick(); chk("t5_w1", DATAUP, 32'h1000_0014);
    URST = 1'b1; ACK = 1'b0;
    tick();
    chk("t5_rst_vld", {31'b0, DATAVALID}, 32'd0);
    chk("t5_rst_delay", {31'b0, DELAY}, 32'd0);
    chk("t5_rst_drops", {16'b0, DROPS}, 32'd0);
    URST = 1'b0;
    tick();
    chk("t5_post_vld", {31'b0, DATAVALID}, 32'd0);
    chk("t5_post_delay", {31'b0, DELAY}, 32'd0);
    PROBE_DATA = smp(40); PROBE_EN = 1'b1;
    tick(); PROBE_EN = 1'b0;
    chk("t5_fresh_hdr", DATAUP, H0);
    ACK = 1'b1;
    pkt("t5_p40", 40, 1'b0, 32'd0);

    // ENABLE=0 blocks capture but buffered samples still drain.
    ACK = 1'b0;
    for (int k = 30; k < 32; k++) begin
      PROBE_DATA = smp(k); PROBE_EN = 1'b1;
      tick();
    end
    ENABLE = 1'b0; PROBE_DATA = smp(55);
    tick(); PROBE_EN = 1'b0;
    chk("t6_drops", {16'b0, DROPS}, 32'd0);
    chk("t6_hdr", DATAUP, H0);
    ACK = 1'b1;
    pkt("t6_p30", 30, 1'b1, H0);
    pkt("t6_p31", 31, 1'b0, 32'd0);
    tick(); tick(); tick();
    chk("t6_no_third", {31'b0, DATAVALID}, 32'd0);
    chk("t6_delay", {31'b0, DELAY}, 32'd0);
    chk("t6_drops_end", {16'b0, DROPS}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
